// File: rtl/ysyx_22050612_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package ysyx_22050612_pkg;

    // Arbiter FSM: accept in IDLE, hold request in REQ, wait for data in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Which requester owns the in-flight transaction.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

endpackage

// File: rtl/ysyx_22050612_arb_pick.sv
// Priority pick between fetch and load/store. On a tie the requester that
// did not win last time is chosen. Tying last_gnt to GNT_IF gives plain
// load/store-first priority.
module ysyx_22050612_arb_pick
    import ysyx_22050612_pkg::*;
(
    input  logic if_valid,
    input  logic ls_valid,
    input  logic last_gnt,
    output logic gnt_c
);

    // Tie goes to whoever was not granted last; otherwise the sole requester.
    always_comb begin
        gnt_c = GNT_IF;
        if (if_valid && ls_valid) begin
            gnt_c = (last_gnt == GNT_LS) ? GNT_IF : GNT_LS;
        end else if (ls_valid) begin
            gnt_c = GNT_LS;
        end
    end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// single transaction in flight. Define YSYX_22050612_ARB_RR_EN to alternate
// priority on simultaneous requests; otherwise load/store always wins a tie.
module ysyx_22050612_mem_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,

    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic                 gnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 wen_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [MASK_W-1:0]    wmask_q;

    logic                 pick_c;
    logic                 last_gnt;
    logic                 accept_c;

    ysyx_22050612_arb_pick u_pick (
        .if_valid (if_valid),
        .ls_valid (ls_valid),
        .last_gnt (last_gnt),
        .gnt_c    (pick_c)
    );

`ifdef YSYX_22050612_ARB_RR_EN
    logic last_gnt_q;

    // Remember the last winner; starts at load/store so fetch takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_LS;
        end else if (accept_c) begin
            last_gnt_q <= pick_c;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_IF;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and response routing.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        if_ready  = 1'b0;
        ls_ready  = 1'b0;
        mem_valid = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // rst_n gate keeps ready low while reset is held.
                if (rst_n && (if_valid || ls_valid)) begin
                    accept_c = 1'b1;
                    if_ready = (pick_c == GNT_IF);
                    ls_ready = (pick_c == GNT_LS);
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    if_rvalid = (gnt_q == GNT_IF);
                    ls_rvalid = (gnt_q == GNT_LS);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request fields; fetch is always a plain read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= GNT_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept_c) begin
            gnt_q <= pick_c;
            if (pick_c == GNT_LS) begin
                addr_q  <= ls_addr;
                wen_q   <= ls_wen;
                wdata_q <= ls_wdata;
                wmask_q <= ls_wmask;
            end else begin
                addr_q  <= if_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    // Read data is broadcast; rvalid qualifies it.
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for the fetch / load-store memory arbiter.
module tb_ysyx_22050612_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_valid, if_ready, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_valid, ls_ready, ls_wen, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [MW-1:0] ls_wmask;
    logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_valid   (ls_valid),
        .ls_ready   (ls_ready),
        .ls_addr    (ls_addr),
        .ls_wen     (ls_wen),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic          who;   // 1 = load/store
        logic [DW-1:0] data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    logic gnt_log[$];
    int   acc_log[$];
    int   rsp_log[$];
    exp_t mon_e;

    // Memory responder knobs and handshake capture.
    bit            resp_en = 1'b1;
    bit            spur    = 1'b0;
    bit            hs_pend = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic          hs_wen  = 1'b0;

    // Pending requests and the currently granted one.
    bit            p_if = 1'b0, p_ls = 1'b0;
    logic [AW-1:0] p_if_addr, p_ls_addr;
    logic          p_ls_wen;
    logic [DW-1:0] p_ls_wdata;
    logic [MW-1:0] p_ls_wmask;
    bit            c_act = 1'b0, c_seen = 1'b0;
    int            c_acc = 0;
    logic [AW-1:0] c_addr;
    logic          c_wen;
    logic [DW-1:0] c_wdata;
    logic [MW-1:0] c_wmask;
    int            stall_left = 0;
    int            req_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input logic wen);
        if (wen) return '0;
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0010_0073;
        return a ^ 64'hA5A5_0000_5A5A_FFFF;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        hs_pend = rst_n && mem_valid && mem_ready;
        hs_addr = mem_addr;
        hs_wen  = mem_wen;
    end

    always @(posedge clk) begin
        #1;
        mem_rvalid = (hs_pend && resp_en) || spur;
        mem_rdata  = hs_pend ? mem_data(hs_addr, hs_wen) : 64'h0BAD_0BAD_0BAD_0BAD;
    end

    // Response monitor: every rvalid must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (if_rvalid || ls_rvalid)) begin
            chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("rsp_onehot", 64'(if_rvalid & ls_rvalid), 64'd0);
                chk("rsp_who", 64'(ls_rvalid), 64'(mon_e.who));
                chk("rsp_data", mon_e.who ? ls_rdata : if_rdata, mon_e.data);
                rsp_log.push_back(cyc);
            end
        end
    end

    task automatic post_if(input logic [AW-1:0] a);
        p_if = 1'b1; p_if_addr = a;
        if_valid = 1'b1; if_addr = a;
    endtask

    task automatic post_ls(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           input logic [MW-1:0] m);
        p_ls = 1'b1; p_ls_addr = a; p_ls_wen = w; p_ls_wdata = d; p_ls_wmask = m;
        ls_valid = 1'b1; ls_addr = a; ls_wen = w; ls_wdata = d; ls_wmask = m;
    endtask

    // Drive pending requests to completion, checking handshakes and the memory side.
    task automatic run(input int max_cyc);
        int n;
        bit drop_if, drop_ls;
        n = 0;
        while ((p_if || p_ls || c_act || sb_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            drop_if = 1'b0;
            drop_ls = 1'b0;
            if (if_ready || ls_ready)
                chk("ready_onehot", 64'(if_ready & ls_ready), 64'd0);
            if (ls_ready) begin
                chk("ls_ready_valid", 64'(p_ls), 64'd1);
                c_addr = p_ls_addr; c_wen = p_ls_wen; c_wdata = p_ls_wdata; c_wmask = p_ls_wmask;
                sb_q.push_back('{who: 1'b1, data: mem_data(p_ls_addr, p_ls_wen)});
                gnt_log.push_back(1'b1);
                acc_log.push_back(cyc);
                c_act = 1'b1; c_seen = 1'b0; c_acc = cyc; drop_ls = 1'b1;
            end else if (if_ready) begin
                chk("if_ready_valid", 64'(p_if), 64'd1);
                c_addr = p_if_addr; c_wen = 1'b0; c_wdata = '0; c_wmask = '0;
                sb_q.push_back('{who: 1'b0, data: mem_data(p_if_addr, 1'b0)});
                gnt_log.push_back(1'b0);
                acc_log.push_back(cyc);
                c_act = 1'b1; c_seen = 1'b0; c_acc = cyc; drop_if = 1'b1;
            end
            if (mem_valid) begin
                req_cnt++;
                if (!c_seen) begin
                    chk("req_lat", 64'(cyc - c_acc), 64'd1);
                    c_seen = 1'b1;
                end
                chk("req_no_ready", 64'({if_ready, ls_ready}), 64'd0);
                chk("mem_addr", mem_addr, c_addr);
                chk("mem_wen", 64'(mem_wen), 64'(c_wen));
                chk("mem_wdata", mem_wdata, c_wdata);
                chk("mem_wmask", 64'(mem_wmask), 64'(c_wmask));
                if (mem_rvalid)
                    chk("rvalid_in_req", 64'({if_rvalid, ls_rvalid}), 64'd0);
                if (mem_ready) c_act = 1'b0;
                spur = (stall_left == 3);
                if (stall_left > 0) stall_left--;
            end else begin
                spur = 1'b0;
            end
            @(posedge clk);
            #1;
            if (drop_if) begin if_valid = 1'b0; p_if = 1'b0; end
            if (drop_ls) begin ls_valid = 1'b0; p_ls = 1'b0; end
            if (stall_left == 0) mem_ready = 1'b1;
            n++;
        end
        chk("run_in_budget", 64'(n < max_cyc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        if_valid = 1'b0; if_addr = '0;
        ls_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with both requesters asking.
        if_valid = 1'b1; ls_valid = 1'b1;
        @(negedge clk);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_ls_ready", 64'(ls_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        chk("rst_if_rdata", if_rdata, mem_rdata);
        chk("rst_ls_rdata", ls_rdata, mem_rdata);
        if_valid = 1'b0; ls_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch only, minimum latency.
        acc_log.delete(); rsp_log.delete();
        post_if(64'h0000_0000_8000_0000);
        run(20);
        chk("fetch_rsp_lat", 64'(rsp_log[0] - acc_log[0]), 64'd2);

        // Store, then a load.
        post_ls(64'h0000_0000_8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'hF0);
        run(20);
        post_ls(64'h0000_0000_8000_2008, 1'b0, 64'hFFFF_0000_FFFF_0000, 8'h0F);
        run(20);

        // Simultaneous requests, twice in a row.
        gnt_log.delete(); acc_log.delete(); rsp_log.delete();
        post_if(64'h0000_0000_8000_0100);
        post_ls(64'h0000_0000_8000_3000, 1'b0, '0, '0);
        run(40);
        chk("b2b_accept", 64'(acc_log[1] - rsp_log[0]), 64'd1);
        post_if(64'h0000_0000_8000_0104);
        post_ls(64'h0000_0000_8000_3008, 1'b1, 64'hCAFE_F00D_DEAD_BEEF, 8'h3C);
        run(40);
        chk("tie_count", 64'(gnt_log.size()), 64'd4);
`ifdef YSYX_22050612_ARB_RR_EN
        chk("tie_g0", 64'(gnt_log[0]), 64'd0);
        chk("tie_g1", 64'(gnt_log[1]), 64'd1);
        chk("tie_g2", 64'(gnt_log[2]), 64'd0);
        chk("tie_g3", 64'(gnt_log[3]), 64'd1);
`else
        chk("tie_g0", 64'(gnt_log[0]), 64'd1);
        chk("tie_g1", 64'(gnt_log[1]), 64'd0);
        chk("tie_g2", 64'(gnt_log[2]), 64'd1);
        chk("tie_g3", 64'(gnt_log[3]), 64'd0);
`endif

        // mem_ready low for 5 cycles, with a stray mem_rvalid inside REQ.
        req_cnt = 0;
        mem_ready = 1'b0;
        stall_left = 5;
        post_ls(64'h0000_0000_8000_4010, 1'b0, '0, 8'hFF);
        run(40);
        chk("stall_req_cycles", 64'(req_cnt), 64'd6);

        // Reset while waiting in RESP drops the transaction.
        resp_en = 1'b0;
        if_valid = 1'b1; if_addr = 64'h0000_0000_8000_5000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ready && n < 10);
        chk("rstx_accept", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("rstx_req", 64'(mem_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstx_resp_idle_bus", 64'(mem_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rstx_mem_valid", 64'(mem_valid), 64'd0);
        chk("rstx_mem_addr", mem_addr, 64'd0);
        chk("rstx_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        rst_n = 1'b1;

        // Spurious mem_rvalid in IDLE (also proves the dropped transaction is gone).
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_mem_valid", 64'(mem_valid), 64'd0);
        chk("spur_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        @(posedge clk);
        #1;

        // Fetch after reset completes normally.
        acc_log.delete(); rsp_log.delete();
        post_if(64'h0000_0000_8000_0000);
        run(20);
        chk("post_rst_fetch_lat", 64'(rsp_log[0] - acc_log[0]), 64'd2);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
YSYX_22050612_MEM_ARBITER -- requirements
Module: ysyx_22050612_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; wmask width is DATA_W/8.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch read request.
- if_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_rvalid  out  1  fetch response, one-cycle pulse.
- if_rdata  out  DATA_W  fetch read data.
- ls_valid  in  1  load/store request.
- ls_ready  out  1  load/store request accepted this cycle.
- ls_addr  in  ADDR_W  load/store address.
- ls_wen  in  1  1 = write, 0 = read.
- ls_wdata  in  DATA_W  write data.
- ls_wmask  in  DATA_W/8  byte write mask.
- ls_rvalid  out  1  load/store response (read data or write ack), one-cycle pulse.
- ls_rdata  out  DATA_W  load read data.
- mem_valid  out  1  request to the shared memory port.
- mem_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte mask.
- mem_rvalid  in  1  memory response, for both reads and writes.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-003 The block SHALL share one memory port between fetch and load/store, with one transaction outstanding at a time.
REQ-004 The FSM SHALL have states IDLE, REQ and RESP.
REQ-005 In IDLE, when either valid is high, the block SHALL:
- assert ready to exactly one requester, combinationally, that cycle;
- latch that requester's address, wen, wdata and wmask, plus a grant flag;
- move to REQ.
REQ-006 if_ready and ls_ready SHALL be 0 in REQ and RESP.
REQ-007 A fetch request SHALL drive mem_wen=0, mem_wmask=0 and mem_wdata=0.
REQ-008 In REQ, mem_valid SHALL be 1 with the latched fields held stable until mem_ready; on mem_valid and mem_ready the FSM SHALL move to RESP.
REQ-009 In RESP, mem_rvalid SHALL raise the granted requester's rvalid in the same cycle, with rdata equal to mem_rdata; the FSM SHALL then return to IDLE.
REQ-010 The non-granted rvalid SHALL stay 0.
REQ-011 Both rdata outputs SHALL carry mem_rdata continuously; rdata is valid only while the matching rvalid is high.
REQ-012 mem_rvalid outside RESP SHALL be ignored.
REQ-013 Minimum latency SHALL be: accept at cycle N, mem_valid at N+1, response at N+2.
REQ-014 Back-to-back: a request SHALL be acceptable in the IDLE cycle immediately after the response cycle.
REQ-015 With both valids high in IDLE, load/store SHALL win (fixed priority) unless YSYX_22050612_ARB_RR_EN is defined.

Reset
REQ-016 While rst_n is low, the FSM SHALL be IDLE and the grant and latched-field registers SHALL be 0.
REQ-017 During reset, all outputs SHALL be 0, except if_rdata and ls_rdata, which follow mem_rdata.
REQ-018 Reset asserted mid-transaction SHALL drop the transaction; no rvalid SHALL be produced for it.

Configuration
REQ-019 With YSYX_22050612_ARB_RR_EN defined:
- a last-grant register SHALL alternate priority on simultaneous requests;
- it resets to "load/store" so that fetch wins the first tie.
Without the macro, the register SHALL be absent and fixed load/store priority SHALL apply.

Structure
REQ-020 FSM state encoding and the grant encoding (GNT_IF, GNT_LS) SHALL live in package ysyx_22050612_pkg.
REQ-021 One sub-module, ysyx_22050612_arb_pick (valids and last grant in, grant out), SHALL hold the priority logic; all else is flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Fetch only: if_addr=0x80000000, mem_ready=1, mem_rvalid two cycles later with rdata=0x00100073 -> if_ready at N; mem_valid at N+1; if_rvalid=1 and if_rdata=0x00100073 for one cycle; ls_rvalid stays 0.
- Store: ls_wen=1, addr=0x80001000, wdata=0x1122334455667788, wmask=0xF0 -> mem_wen=1 with identical fields; ls_rvalid pulses on mem_rvalid.
- Simultaneous requests, macro off -> ls_ready first, if_ready after the LSU response. Macro on -> fetch first, load/store second, fetch third on a repeated tie.
- mem_ready held low for 5 cycles -> mem_valid and mem_addr stable throughout; no ready to either requester.
- rst_n pulsed low in RESP before mem_rvalid -> state IDLE, mem_valid=0, no rvalid; a following fetch completes normally.
- Spurious mem_rvalid in IDLE -> no rvalid output.
